// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern path: mode encodings and the
// scheduler state type.
package vga_pkg;

  localparam int unsigned NUM_MODES = 3;

  localparam logic [1:0] MODE_BAR_X = 2'd0;
  localparam logic [1:0] MODE_BAR_Y = 2'd1;
  localparam logic [1:0] MODE_CHESS = 2'd2;

  typedef enum logic {
    StIdle,
    StPend
  } sched_state_e;

endpackage

// File: rtl/key_debounce.sv
// Board-key conditioner: 2-flop synchroniser, stability counter and a
// one-cycle request pulse on each accepted press (active-low key).
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_req
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic            key_meta_q;
  logic            key_sync_q;
  logic            key_db_q;
  logic            key_req_q;
  logic [CntW-1:0] cnt_q;

  // The counter measures how long the synchronised key has disagreed with the
  // accepted level; any agreement (bounce back) restarts the measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      key_db_q   <= 1'b1;
      key_req_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      key_meta_q <= key;
      key_sync_q <= key_meta_q;
      key_req_q  <= 1'b0;
      if (key_sync_q == key_db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        key_db_q  <= key_sync_q;
        cnt_q     <= '0;
        key_req_q <= ~key_sync_q;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign key_req = key_req_q;

endmodule

// File: rtl/vga_mode_sched.sv
// Display-mode scheduler: collects manual and auto-advance requests and
// applies at most one mode step per frame, only at a vsync falling edge.
module vga_mode_sched
  import vga_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 250000,
  parameter int unsigned AUTO_FRAMES = 120,
  parameter int unsigned NUM_MODES   = vga_pkg::NUM_MODES
) (
  input  logic       iPixclk,
  input  logic       iRst,
  input  logic       iVs,
  input  logic       iKey,
  input  logic       iAuto,
  output logic [1:0] oMode,
  output logic       oFrame_Tick,
  output logic       oPending
);

  localparam int unsigned FrameW = $clog2(AUTO_FRAMES + 1);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(AUTO_FRAMES - 1);
  localparam logic [1:0] ModeLast = 2'(NUM_MODES - 1);

  logic              vs_d;
  logic              fe;
  logic              tick_q;
  logic              auto_meta_q;
  logic              auto_s_q;
  logic              key_req;
  logic              auto_req;
  logic              advance;
  logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]        mode_q, mode_d;
  sched_state_e      state_q, state_d;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_key_debounce (
    .clk    (iPixclk),
    .rst_n  (iRst),
    .key    (iKey),
    .key_req(key_req)
  );

  assign fe = vs_d & ~iVs;

  always_ff @(posedge iPixclk or negedge iRst) begin
    if (!iRst) begin
      vs_d        <= 1'b0;
      tick_q      <= 1'b0;
      auto_meta_q <= 1'b0;
      auto_s_q    <= 1'b0;
      frame_cnt_q <= '0;
      mode_q      <= MODE_BAR_X;
      state_q     <= StIdle;
    end else begin
      vs_d        <= iVs;
      tick_q      <= fe;
      auto_meta_q <= iAuto;
      auto_s_q    <= auto_meta_q;
      frame_cnt_q <= frame_cnt_d;
      mode_q      <= mode_d;
      state_q     <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    auto_req    = 1'b0;
    advance     = (state_q == StPend) && fe;

    // An applied advance restarts the auto interval, so a manual press
    // pushes the next automatic step a full interval away.
    if (!auto_s_q) begin
      frame_cnt_d = '0;
    end else if (fe) begin
      if (advance) begin
        frame_cnt_d = '0;
      end else if (frame_cnt_q == FrameLast) begin
        frame_cnt_d = '0;
        auto_req    = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + FrameW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (key_req || auto_req) state_d = StPend;
      end
      StPend: begin
        if (fe) begin
          state_d = StIdle;
          mode_d  = (mode_q == ModeLast) ? MODE_BAR_X : mode_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign oMode       = mode_q;
  assign oFrame_Tick = tick_q;
  assign oPending    = (state_q == StPend);

endmodule

// File: tb/tb_vga_mode_sched.sv
// Randomised bench for vga_mode_sched against a behavioural model built from
// input histories (sync delay, stability window, frame-rule bookkeeping).
module tb_vga_mode_sched;

  localparam int unsigned DEB = 4;
  localparam int unsigned AF  = 3;
  localparam int unsigned NM  = 3;

  logic       clk = 1'b0;
  logic       iRst = 1'b1;
  logic       iVs;
  logic       iKey;
  logic       iAuto;
  logic [1:0] oMode;
  logic       oFrame_Tick;
  logic       oPending;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int len;
  int per;
  int kind;
  int guard;

  // Reference model state
  bit key_h[$];
  bit auto_h[$];
  bit vs_h[$];
  int m_mode;
  bit m_pend;
  bit m_tick;
  bit m_db;
  bit m_kreq;
  int m_frames;

  vga_mode_sched #(
    .DEB_CYCLES (DEB),
    .AUTO_FRAMES(AF),
    .NUM_MODES  (NM)
  ) dut (
    .iPixclk    (clk),
    .iRst       (iRst),
    .iVs        (iVs),
    .iKey       (iKey),
    .iAuto      (iAuto),
    .oMode      (oMode),
    .oFrame_Tick(oFrame_Tick),
    .oPending   (oPending)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Values seen 'back' cycles ago; before reset release the flops hold their
  // reset levels, which is what the defaults stand for.
  function automatic bit key_at(int back);
    if (key_h.size() > back) return key_h[key_h.size() - 1 - back];
    return 1'b1;
  endfunction

  function automatic bit auto_at(int back);
    if (auto_h.size() > back) return auto_h[auto_h.size() - 1 - back];
    return 1'b0;
  endfunction

  function automatic bit vs_at(int back);
    if (vs_h.size() > back) return vs_h[vs_h.size() - 1 - back];
    return 1'b0;
  endfunction

  function automatic void model_reset();
    key_h.delete();
    auto_h.delete();
    vs_h.delete();
    m_mode   = 0;
    m_pend   = 1'b0;
    m_tick   = 1'b0;
    m_db     = 1'b1;
    m_kreq   = 1'b0;
    m_frames = 0;
  endfunction

  // One clock edge of the specified behaviour.
  function automatic void model_step();
    bit fe, a, kreq_now, stable, areq, adv;
    key_h.push_back(iKey);
    auto_h.push_back(iAuto);
    vs_h.push_back(iVs);
    if (key_h.size() > 16) begin
      void'(key_h.pop_front());
      void'(auto_h.pop_front());
      void'(vs_h.pop_front());
    end
    fe       = vs_at(1) && !vs_at(0);
    a        = auto_at(2);
    kreq_now = m_kreq;

    // Key accepted once its synchronised level has disagreed with the
    // accepted level for DEB consecutive cycles.
    stable = 1'b1;
    for (int i = 2; i < 2 + DEB; i++) if (key_at(i) == m_db) stable = 1'b0;
    m_kreq = 1'b0;
    if (stable) begin
      m_db   = !m_db;
      m_kreq = !m_db;
    end

    areq = 1'b0;
    adv  = m_pend && fe;
    if (!a) m_frames = 0;
    else if (fe) begin
      if (adv) m_frames = 0;
      else if (m_frames == AF - 1) begin
        m_frames = 0;
        areq     = 1'b1;
      end else m_frames++;
    end

    if (adv) begin
      m_mode = (m_mode + 1) % NM;
      m_pend = 1'b0;
    end else if (!m_pend && (kreq_now || areq)) begin
      m_pend = 1'b1;
    end
    m_tick = fe;
  endfunction

  task automatic step();
    iVs = ((cyc % 50) >= 48) ? 1'b0 : 1'b1;
    cyc++;
    @(posedge clk);
    model_step();
    #1;
    check_val("mode", int'(oMode), m_mode);
    check_val("pending", int'(oPending), int'(m_pend));
    check_val("frame_tick", int'(oFrame_Tick), int'(m_tick));
  endtask

  // Reset is asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    iRst = 1'b0;
    iVs  = 1'b0;
    #1;
    check_val("rst_async_mode", int'(oMode), 0);
    check_val("rst_async_pending", int'(oPending), 0);
    check_val("rst_async_tick", int'(oFrame_Tick), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_hold_mode", int'(oMode), 0);
    check_val("rst_hold_pending", int'(oPending), 0);
    iRst = 1'b1;
    cyc  = 48;
  endtask

  task automatic reset_while_pending();
    iKey  = 1'b0;
    guard = 0;
    while (!m_pend && guard < 400) begin
      step();
      guard++;
    end
    check_val("pend_wait", int'(m_pend), 1);
    do_reset();
    iKey = 1'b1;
  endtask

  initial begin
    iKey  = 1'b1;
    iAuto = 1'b0;
    iVs   = 1'b0;
    cyc   = 48;
    #1;
    do_reset();

    // Quiet start, then bounce that must be rejected.
    repeat (60) step();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) iKey = ~iKey;
      step();
    end
    iKey = 1'b1;
    repeat (40) step();

    // Auto mode alone for several intervals.
    iAuto = 1'b1;
    repeat (900) step();

    // Randomised key/auto activity with resets landing mid-pending.
    for (int s = 0; s < 45; s++) begin
      if ($urandom_range(0, 3) == 0) iAuto = ~iAuto;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        len = $urandom_range(10, 24);
        per = $urandom_range(1, 3);
        for (int i = 0; i < len; i++) begin
          if (i % per == 0) iKey = ~iKey;
          step();
        end
        iKey = 1'b1;
        repeat (10) step();
      end else if (kind == 1) begin
        iKey = 1'b0;
        len  = $urandom_range(5, 200);
        repeat (len) step();
      end else begin
        iKey = 1'b1;
        len  = $urandom_range(3, 150);
        repeat (len) step();
      end
      if (s == 15 || s == 32) reset_while_pending();
    end

    iKey = 1'b1;
    repeat (60) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
